// File: rtl/nrzi_unstuff_rx.sv
// USB-style receiver: NRZI decode, SYNC detect, bit unstuffing and EOP check.
// Define RX_BITCNT_EN to add the bit_cnt output (valid bits in the current packet).
module nrzi_unstuff_rx #(
   parameter int SYNC_ZEROS = 7,
   parameter int STUFF_RUN  = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_en,
   input  logic        dp,
   input  logic        dm,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        pkt_start,
   output logic        pkt_end,
   output logic        pkt_err,
   output logic        busy
`ifdef RX_BITCNT_EN
   ,
   output logic [10:0] bit_cnt
`endif
);

   localparam int ZW = $clog2(SYNC_ZEROS + 1);
   localparam int OW = $clog2(STUFF_RUN + 1);
   localparam logic [ZW-1:0] ZMAX = ZW'(SYNC_ZEROS);
   localparam logic [OW-1:0] OMAX = OW'(STUFF_RUN);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

   state_t        state_q, state_d;
   logic          prev_q, prev_d;
   logic [ZW-1:0] zcnt_q, zcnt_d;
   logic [OW-1:0] ones_q, ones_d;
   logic [1:0]    se0_cnt_q, se0_cnt_d;
   logic          last_se0_q;
   logic          bit_q, bit_d, valid_q, valid_d;
   logic          start_q, start_d, end_q, end_d, err_q, err_d, busy_q;

   logic is_j, is_k, is_se0, is_se1, is_jk, dec;
   assign is_j   = dp & ~dm;
   assign is_k   = ~dp & dm;
   assign is_se0 = ~dp & ~dm;
   assign is_se1 = dp & dm;
   assign is_jk  = is_j | is_k;
   // J is level 1; an unchanged level decodes as 1
   assign dec    = (dp == prev_q);

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      zcnt_d    = zcnt_q;
      ones_d    = ones_q;
      se0_cnt_d = se0_cnt_q;
      bit_d     = 1'b0;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      end_d     = 1'b0;
      err_d     = 1'b0;
      if (is_jk) prev_d = dp;
      if (!rx_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_jk && !dec) begin
                  state_d = SYNC;
                  zcnt_d  = ZW'(1);
               end
            end
            SYNC: begin
               if (is_se1) begin
                  err_d   = 1'b1;
                  state_d = ABORT;
               end else if (is_se0) begin
                  state_d = IDLE;
               end else if (!dec) begin
                  if (zcnt_q == ZMAX) state_d = IDLE;
                  else zcnt_d = zcnt_q + ZW'(1);
               end else if (zcnt_q == ZMAX) begin
                  state_d = DATA;
                  start_d = 1'b1;
                  ones_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            DATA: begin
               if (is_se1) begin
                  err_d   = 1'b1;
                  state_d = ABORT;
               end else if (is_se0) begin
                  state_d   = EOP;
                  se0_cnt_d = 2'd1;
               end else if (ones_q == OMAX) begin
                  // a full run of ones must be followed by the stuffed zero
                  if (dec) begin
                     err_d   = 1'b1;
                     state_d = ABORT;
                  end else begin
                     ones_d = '0;
                  end
               end else begin
                  bit_d   = dec;
                  valid_d = 1'b1;
                  ones_d  = dec ? ones_q + OW'(1) : '0;
               end
            end
            EOP: begin
               if (is_se0) begin
                  if (se0_cnt_q != 2'd3) se0_cnt_d = se0_cnt_q + 2'd1;
               end else if (is_j) begin
                  end_d   = (se0_cnt_q == 2'd2);
                  err_d   = (se0_cnt_q != 2'd2);
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ABORT;
               end
            end
            ABORT: begin
               if (is_se1) err_d = 1'b1;
               else if (is_j && last_se0_q) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prev_q     <= 1'b1;
         zcnt_q     <= '0;
         ones_q     <= '0;
         se0_cnt_q  <= '0;
         last_se0_q <= 1'b0;
         bit_q      <= 1'b0;
         valid_q    <= 1'b0;
         start_q    <= 1'b0;
         end_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         zcnt_q     <= zcnt_d;
         ones_q     <= ones_d;
         se0_cnt_q  <= se0_cnt_d;
         last_se0_q <= is_se0;
         bit_q      <= bit_d;
         valid_q    <= valid_d;
         start_q    <= start_d;
         end_q      <= end_d;
         err_q      <= err_d;
         busy_q     <= (state_d != IDLE);
      end
   end

   assign bit_out   = bit_q;
   assign bit_valid = valid_q;
   assign pkt_start = start_q;
   assign pkt_end   = end_q;
   assign pkt_err   = err_q;
   assign busy      = busy_q;

`ifdef RX_BITCNT_EN
   logic [10:0] bit_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) bit_cnt_q <= '0;
      else if (start_d) bit_cnt_q <= '0;
      else if (valid_d && bit_cnt_q != 11'd2047) bit_cnt_q <= bit_cnt_q + 11'd1;
   end
   assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Randomised packet-level bench for nrzi_unstuff_rx: packets are built from bytes,
// stuffed and NRZI-encoded here; a monitor scores every DUT pulse against a queue.
module tb_nrzi_unstuff_rx;

   localparam int STUFF   = 6;
   localparam int C_START = 2;
   localparam int C_END   = 3;
   localparam int C_ERR   = 4;

   logic clk = 1'b0;
   logic rst, rx_en, dp, dm;
   logic bit_out, bit_valid, pkt_start, pkt_end, pkt_err, busy;
`ifdef RX_BITCNT_EN
   logic [10:0] bit_cnt;
`endif

   nrzi_unstuff_rx #(.SYNC_ZEROS(7), .STUFF_RUN(STUFF)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_en     (rx_en),
      .dp        (dp),
      .dm        (dm),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .pkt_start (pkt_start),
      .pkt_end   (pkt_end),
      .pkt_err   (pkt_err),
      .busy      (busy)
`ifdef RX_BITCNT_EN
      ,
      .bit_cnt   (bit_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int code; int at; int cnt; } ev_t;
   typedef struct { int at; logic val; } busy_t;
   ev_t   exp_q[$];
   busy_t busy_q[$];

   int   checks = 0;
   int   failures = 0;
   int   last_rc = 0;
   logic lvl = 1'b1;
   logic en_n = 1'b1;
   logic rst_n = 1'b1;
   int   ones = 0;
   int   nbits = 0;

   function automatic string ename(input int c);
      case (c)
         0: return "bit0";
         1: return "bit1";
         2: return "start";
         3: return "end";
         4: return "err";
         default: return "none";
      endcase
   endfunction

   // one line sample; the response to it is expected on the following cycle
   task automatic samp(input logic p, input logic m, input int code, input int cnt = 0);
      @(negedge clk);
      rst   = rst_n;
      rx_en = en_n;
      dp    = p;
      dm    = m;
      last_rc = cyc + 1;
      if (code >= 0) exp_q.push_back('{code, cyc + 1, cnt});
   endtask

   task automatic exp_busy(input logic v);
      busy_q.push_back('{last_rc, v});
   endtask

   task automatic send_bit(input logic b, input int code);
      if (!b) lvl = ~lvl;
      samp(lvl, ~lvl, code);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) samp(1'b1, 1'b0, -1);
      lvl = 1'b1;
   endtask

   task automatic sync_ok();
      for (int i = 0; i < 7; i++) send_bit(1'b0, -1);
      send_bit(1'b1, C_START);
      exp_busy(1'b1);
      ones  = 0;
      nbits = 0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         send_bit(v[i], v[i] ? 1 : 0);
         nbits++;
         ones = v[i] ? ones + 1 : 0;
         if (ones == STUFF) begin
            send_bit(1'b0, -1);
            ones = 0;
         end
      end
   endtask

   task automatic send_data(input int nbytes, input bit force_ff);
      for (int k = 0; k < nbytes; k++) begin
         if (force_ff && k == 0) send_byte(8'hFF);
         else send_byte(8'($urandom));
      end
   endtask

   task automatic eop(input int n);
      for (int i = 0; i < n; i++) samp(1'b0, 1'b0, -1);
      lvl = 1'b1;
      samp(1'b1, 1'b0, (n == 2) ? C_END : C_ERR, (nbits > 2047) ? 2047 : nbits);
      exp_busy(1'b0);
   endtask

   task automatic junk_and_recover();
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) send_bit(1'($urandom), -1);
      samp(1'b0, 1'b0, -1);
      lvl = 1'b1;
      samp(1'b1, 1'b0, -1);
      exp_busy(1'b0);
   endtask

   task automatic good_pkt(input bit force_ff);
      sync_ok();
      send_data($urandom_range(1, 6), force_ff);
      eop(2);
   endtask

   task automatic scenario(input int s);
      int n;
      if ($urandom_range(0, 3) == 0) samp(1'b1, 1'b1, -1);
      idle($urandom_range(2, 5));
      case (s)
         0, 1: good_pkt(s == 1);
         2: begin
            sync_ok();
            send_data($urandom_range(0, 2), 1'b0);
            send_bit(1'b0, 0);
            for (int i = 0; i < STUFF; i++) send_bit(1'b1, 1);
            send_bit(1'b1, C_ERR);
            exp_busy(1'b1);
            junk_and_recover();
         end
         3: begin
            sync_ok();
            send_data($urandom_range(1, 3), 1'b0);
            n = $urandom_range(0, 2);
            eop((n == 0) ? 1 : n + 2);
         end
         4: begin
            sync_ok();
            send_data($urandom_range(1, 2), 1'b0);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) samp(1'b0, 1'b0, -1);
            lvl = 1'b0;
            samp(1'b0, 1'b1, C_ERR);
            exp_busy(1'b1);
            junk_and_recover();
         end
         5: begin
            sync_ok();
            send_data($urandom_range(0, 2), 1'b0);
            samp(1'b1, 1'b1, C_ERR);
            exp_busy(1'b1);
            junk_and_recover();
         end
         6: begin
            for (int i = 0; i < 6; i++) send_bit(1'b0, -1);
            send_bit(1'b1, -1);
            exp_busy(1'b0);
         end
         7: begin
            sync_ok();
            send_data($urandom_range(1, 2), 1'b0);
            en_n = 1'b0;
            send_bit(1'($urandom), -1);
            exp_busy(1'b0);
            send_bit(1'($urandom), -1);
            en_n = 1'b1;
            idle(3);
            good_pkt(1'b0);
         end
         default: begin
            sync_ok();
            send_data($urandom_range(1, 2), 1'b0);
            rst_n = 1'b1;
            samp(1'b1, 1'b0, -1);
            lvl = 1'b1;
            exp_busy(1'b0);
            samp(1'b1, 1'b0, -1);
            rst_n = 1'b0;
            idle(3);
            good_pkt(1'b0);
         end
      endcase
   endtask

   // monitor: scores every pulse and scheduled busy level on the falling edge
   int ev;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         checks++;
         failures++;
         $display("FAIL missing_event cyc=%0d got none required %s", cyc, ename(exp_q[0].code));
         exp_q.delete(0);
      end
      checks++;
      if ((bit_out && !bit_valid) ||
          (int'(bit_valid) + int'(pkt_start) + int'(pkt_end) + int'(pkt_err) > 1)) begin
         failures++;
         $display("FAIL pulse_rules cyc=%0d got out=%b valid=%b start=%b end=%b err=%b required at most one pulse and out=0 without valid",
                  cyc, bit_out, bit_valid, pkt_start, pkt_end, pkt_err);
      end
      ev = -1;
      if (bit_valid) ev = bit_out ? 1 : 0;
      else if (pkt_start) ev = C_START;
      else if (pkt_end) ev = C_END;
      else if (pkt_err) ev = C_ERR;
      if (ev >= 0) begin
         checks++;
         if (exp_q.size() == 0 || exp_q[0].at != cyc) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got %s required none", cyc, ename(ev));
         end else begin
            if (exp_q[0].code != ev) begin
               failures++;
               $display("FAIL event cyc=%0d got %s required %s", cyc, ename(ev), ename(exp_q[0].code));
            end
`ifdef RX_BITCNT_EN
            if (exp_q[0].code == C_END) begin
               checks++;
               if (bit_cnt != 11'(exp_q[0].cnt)) begin
                  failures++;
                  $display("FAIL bit_cnt cyc=%0d got %0d required %0d", cyc, bit_cnt, exp_q[0].cnt);
               end
            end
`endif
            exp_q.delete(0);
         end
      end
      while (busy_q.size() > 0 && busy_q[0].at <= cyc) begin
         if (busy_q[0].at == cyc) begin
            checks++;
            if (busy !== busy_q[0].val) begin
               failures++;
               $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, busy_q[0].val);
            end
         end
         busy_q.delete(0);
      end
   end

   initial begin
      logic [7:0] a5;
      rst = 1'b1;
      rx_en = 1'b1;
      dp = 1'b1;
      dm = 1'b0;
      for (int i = 0; i < 3; i++) samp(1'b1, 1'b0, -1);
      exp_busy(1'b0);
      rst_n = 1'b0;
      idle(5);
      exp_busy(1'b0);

      // KJKJKJKK sync, 0xA5 LSB-first, SE0 SE0 J
      sync_ok();
      a5 = 8'hA5;
      send_byte(a5);
      eop(2);
      idle(3);

      for (int s = 0; s < 9; s++) scenario(s);
      for (int i = 0; i < 30; i++) scenario($urandom_range(0, 8));
      idle(4);
      @(negedge clk);
      @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events got %0d required 0", exp_q.size());
      end
      checks++;
      if (busy_q.size() != 0) begin
         failures++;
         $display("FAIL pending_busy got %0d required 0", busy_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nrzi_unstuff_rx.md
NRZI_UNSTUFF_RX -- requirements
Module: nrzi_unstuff_rx

Interface
REQ-001 SHALL have parameter SYNC_ZEROS, default 7: number of decoded 0s that precede the final decoded 1 of SYNC.
REQ-002 SHALL have parameter STUFF_RUN, default 6: number of consecutive decoded 1s after which a stuffed 0 is expected.
REQ-003 SHALL have port clk  input  1  the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_en  input  1  receiver enable.
REQ-006 SHALL have port dp  input  1  line D+ sample, one sample per bit time, already bit-aligned.
REQ-007 SHALL have port dm  input  1  line D- sample.
REQ-008 SHALL have port bit_out  output  1  decoded and unstuffed data bit.
REQ-009 SHALL have port bit_valid  output  1  bit_out is valid this cycle.
REQ-010 SHALL have port pkt_start  output  1  one-cycle pulse when SYNC completes.
REQ-011 SHALL have port pkt_end  output  1  one-cycle pulse on a valid EOP.
REQ-012 SHALL have port pkt_err  output  1  one-cycle pulse on a stuff, EOP or SE1 error.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL classify each sample as J (dp=1, dm=0), K (dp=0, dm=1), SE0 (0,0) or SE1 (1,1).
REQ-015 SHALL NRZI-decode each J/K sample as decoded=1 if its level equals register prev, else 0, where J=1 and K=0; prev SHALL then load the sample's level. SE0/SE1 SHALL leave prev unchanged.
REQ-016 SHALL implement the states IDLE, SYNC, DATA, EOP and ABORT.
REQ-017 IDLE: a decoded 0 SHALL go to SYNC with zero count=1; all other samples SHALL stay in IDLE.
REQ-018 SYNC, decoded 0: SHALL increment the zero count; if the count would exceed SYNC_ZEROS, SHALL go to IDLE.
REQ-019 SYNC, decoded 1: if count==SYNC_ZEROS, SHALL go to DATA, pulse pkt_start and clear the ones count; otherwise SHALL go to IDLE.
REQ-020 SYNC, SE0: SHALL go to IDLE with no pulse.
REQ-021 DATA, ones count < STUFF_RUN: SHALL emit the decoded bit with bit_valid=1; a decoded 1 SHALL increment the ones count and a decoded 0 SHALL clear it.
REQ-022 DATA, ones count == STUFF_RUN, decoded 0: SHALL drop the bit (bit_valid=0) and clear the ones count.
REQ-023 DATA, ones count == STUFF_RUN, decoded 1: SHALL pulse pkt_err and go to ABORT, with no bit emitted.
REQ-024 DATA, SE0: SHALL go to EOP with SE0 count=1 and emit no bit.
REQ-025 EOP, SE0: SHALL increment the SE0 count, saturating at 3.
REQ-026 EOP, J: if SE0 count==2, SHALL pulse pkt_end; otherwise SHALL pulse pkt_err; in both cases SHALL then go to IDLE.
REQ-027 EOP, K: SHALL pulse pkt_err and go to ABORT.
REQ-028 ABORT: SHALL stay until a J sample that immediately follows at least one SE0, then go to IDLE with no pulse.
REQ-029 SE1 in any state except IDLE SHALL pulse pkt_err and go to ABORT; SE1 in IDLE SHALL be ignored.
REQ-030 All outputs SHALL be registered, so the response to a sample appears on the cycle after that sample.
REQ-031 bit_valid, pkt_start, pkt_end and pkt_err SHALL be single-cycle pulses, and pkt_end and pkt_err SHALL never be high in the same cycle.
REQ-032 bit_out SHALL be 0 whenever bit_valid=0.
REQ-033 rx_en=0 SHALL force IDLE and zero all pulses on the next cycle, while prev keeps tracking J/K samples.
REQ-034 Deasserting rx_en mid-packet SHALL drop the packet silently with no pkt_err.

Reset
REQ-035 rst=1 at a clock edge SHALL set state=IDLE, prev=J(1) and all counters to 0.
REQ-036 rst=1 SHALL drive bit_out, bit_valid, pkt_start, pkt_end, pkt_err and busy to 0, and bit_cnt (when present) to 0.
REQ-037 Reset mid-packet SHALL abandon the packet with no pulses, and rst SHALL take priority over rx_en.

Configuration
REQ-038 Macro RX_BITCNT_EN defined: SHALL add output port bit_cnt (11 bits), the count of bit_valid pulses in the current packet.
REQ-039 bit_cnt SHALL clear on pkt_start, saturate at 2047, and hold its value after pkt_end/pkt_err until the next pkt_start.
REQ-040 Macro RX_BITCNT_EN undefined: port bit_cnt and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-041 After reset, J idle for 5 cycles -> busy=0 and all pulses 0.
REQ-042 Line KJKJKJKK, then data encoding 0xA5 LSB-first, then SE0,SE0,J -> pkt_start once; bits 1,0,1,0,0,1,0,1 each with bit_valid; pkt_end once; busy=0 afterwards (bit_cnt=8 with RX_BITCNT_EN).
REQ-043 Data of eight decoded 1s with a stuffed 0 after the sixth -> 8 bit_valid pulses all 1, stuffed bit dropped, no pkt_err.
REQ-044 Seven consecutive decoded 1s in DATA -> pkt_err on the cycle after the 7th sample; no further bit_valid until SE0 then J, then IDLE.
REQ-045 EOP with one SE0 then J -> pkt_err and no pkt_end; EOP with three SE0 then J -> pkt_err and no pkt_end.
REQ-046 SYNC with 6 zeros then 1 -> no pkt_start; rst or rx_en=0 pulsed mid-DATA -> next cycle busy=0 with no pulses, and the next good packet decodes correctly.
